// File: rtl/serin_receiver.sv
// serin_receiver: oversampled async serial receiver, start / DW data LSB-first / stop,
// with sticky framing and overrun flags and a one-clk completion irq.
module serin_receiver #(
   parameter int OVS = 16,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enp,
   input  logic          tick,
   input  logic          sid,
   input  logic          serin_rd,
   input  logic          skres,
   output logic [DW-1:0] serin_data,
   output logic          data_valid,
   output logic          serin_irq,
   output logic          frame_err,
   output logic          overrun,
   output logic          rx_busy
);

   localparam int CW = $clog2(OVS);
   localparam int BW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] HALF  = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] LAST  = CW'(OVS - 1);
   localparam logic [BW-1:0] BLAST = BW'(DW - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic          s1;
   logic          sid_s;
   logic          sid_prev;
   logic          step;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bitn;
   logic [DW-1:0] sh;

   assign step    = enp & tick;
   assign rx_busy = (state != IDLE);

   // Two-flop synchronizer runs every clk; it idles high like the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b1;
         sid_s <= 1'b1;
      end else begin
         s1    <= sid;
         sid_s <= s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sid_prev   <= 1'b1;
         cnt        <= '0;
         bitn       <= '0;
         sh         <= '0;
         serin_data <= '0;
         data_valid <= 1'b0;
         serin_irq  <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         serin_irq <= 1'b0;
         if (serin_rd)
            data_valid <= 1'b0;
         if (skres) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         if (step) begin
            sid_prev <= sid_s;
            unique case (state)
               IDLE: begin
                  if (sid_prev && !sid_s) begin
                     state <= START;
                     cnt   <= '0;
                  end
               end
               START: begin
                  if (cnt == HALF) begin
                     if (sid_s) begin
                        state <= IDLE;
                     end else begin
                        state <= DATA;
                        cnt   <= '0;
                        bitn  <= '0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (cnt == LAST) begin
                     sh  <= {sid_s, sh[DW-1:1]};
                     cnt <= '0;
                     if (bitn == BLAST)
                        state <= STOP;
                     else
                        bitn <= bitn + 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (cnt == LAST) begin
                     // a read in this clk counts as preceding the load
                     state      <= IDLE;
                     serin_data <= sh;
                     data_valid <= 1'b1;
                     serin_irq  <= 1'b1;
                     if (!sid_s)
                        frame_err <= 1'b1;
                     if (data_valid && !serin_rd)
                        overrun <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serin_receiver.sv
// tb_serin_receiver: directed frames against a step-history model of the
// receiver, compared every clk, plus literal expectations per scenario.
module tb_serin_receiver;

   localparam int OVS   = 16;
   localparam int DW    = 8;
   localparam int FRAME = (DW + 1) * OVS + OVS / 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enp = 1'b0;
   logic          tick = 1'b0;
   logic          sid = 1'b1;
   logic          serin_rd = 1'b0;
   logic          skres = 1'b0;
   logic [DW-1:0] serin_data;
   logic          data_valid;
   logic          serin_irq;
   logic          frame_err;
   logic          overrun;
   logic          rx_busy;

   int checks = 0;
   int errors = 0;
   int per = 1;
   int pc = 0;
   int irq_cnt = 0;
   int busy_cnt = 0;

   serin_receiver #(.OVS(OVS), .DW(DW)) dut (
      .clk(clk),
      .reset(reset),
      .enp(enp),
      .tick(tick),
      .sid(sid),
      .serin_rd(serin_rd),
      .skres(skres),
      .serin_data(serin_data),
      .data_valid(data_valid),
      .serin_irq(serin_irq),
      .frame_err(frame_err),
      .overrun(overrun),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: keep every synchronized step sample; a frame is judged by
   // indexing the history at mid-bit positions relative to the start step.
   logic          ms1 = 1'b1;
   logic          ms2 = 1'b1;
   logic          mprev = 1'b1;
   logic          mbusy = 1'b0;
   logic          mirq = 1'b0;
   logic [DW-1:0] mdata = '0;
   logic          mdv = 1'b0;
   logic          mfe = 1'b0;
   logic          mov = 1'b0;
   bit            hist[int];
   int            k = 0;
   int            st = 0;

   always @(posedge clk or posedge reset) begin
      logic          cur;
      logic          done;
      logic          stopb;
      logic [DW-1:0] b;
      if (reset) begin
         ms1 = 1'b1;
         ms2 = 1'b1;
         mprev = 1'b1;
         mbusy = 1'b0;
         mirq = 1'b0;
         mdata = '0;
         mdv = 1'b0;
         mfe = 1'b0;
         mov = 1'b0;
      end else begin
         cur = ms2;
         done = 1'b0;
         stopb = 1'b1;
         b = '0;
         if (enp && tick) begin
            k++;
            hist[k] = cur;
            if (!mbusy) begin
               if (mprev && !cur) begin
                  mbusy = 1'b1;
                  st = k;
               end
            end else if (k - st == OVS / 2 && cur) begin
               mbusy = 1'b0;
            end else if (k - st == FRAME) begin
               for (int i = 0; i < DW; i++)
                  b[i] = hist[st + OVS / 2 + OVS * (i + 1)];
               stopb = cur;
               done = 1'b1;
               mbusy = 1'b0;
            end
            mprev = cur;
         end
         mirq = done;
         if (done) begin
            mov = (skres ? 1'b0 : mov) | (mdv & ~serin_rd);
            mfe = (skres ? 1'b0 : mfe) | ~stopb;
            mdv = 1'b1;
            mdata = b;
         end else begin
            if (serin_rd)
               mdv = 1'b0;
            if (skres) begin
               mfe = 1'b0;
               mov = 1'b0;
            end
         end
         ms2 = ms1;
         ms1 = sid;
      end
   end

   always @(negedge clk) begin
      chk("data", 32'(serin_data), 32'(mdata));
      chk("valid", 32'(data_valid), 32'(mdv));
      chk("irq", 32'(serin_irq), 32'(mirq));
      chk("ferr", 32'(frame_err), 32'(mfe));
      chk("ovr", 32'(overrun), 32'(mov));
      chk("busy", 32'(rx_busy), 32'(mbusy));
      if (serin_irq)
         irq_cnt++;
      if (rx_busy)
         busy_cnt++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      serin_rd = 1'b0;
      skres = 1'b0;
      pc = (pc + 1) % per;
      enp = (pc == 0);
      tick = enp;
   endtask

   task automatic hold(input int n);
      repeat (n * per) cyc();
   endtask

   task automatic send(input logic [7:0] d, input logic stopb,
                       input bit rd_done);
      logic [9:0] f;
      f = {stopb, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         sid = f[b];
         for (int j = 0; j < OVS * per; j++) begin
            if (rd_done && b == 9 && j == OVS / 2 + 2)
               serin_rd = 1'b1;
            cyc();
         end
      end
   endtask

   task automatic clear();
      serin_rd = 1'b1;
      skres = 1'b1;
      cyc();
   endtask

   initial begin
      cyc();
      cyc();
      chk("rst_data", 32'(serin_data), 32'h0);
      chk("rst_valid", 32'(data_valid), 32'h0);
      chk("rst_busy", 32'(rx_busy), 32'h0);
      reset = 1'b0;
      hold(10);

      // 1: clean 0xA5
      irq_cnt = 0;
      send(8'hA5, 1'b1, 1'b0);
      hold(20);
      chk("t1_data", 32'(serin_data), 32'hA5);
      chk("t1_mdata", 32'(mdata), 32'hA5);
      chk("t1_valid", 32'(data_valid), 32'h1);
      chk("t1_ferr", 32'(frame_err), 32'h0);
      chk("t1_ovr", 32'(overrun), 32'h0);
      chk("t1_irqs", 32'(irq_cnt), 32'h1);

      // 2: framing error, then skres
      clear();
      send(8'h3C, 1'b0, 1'b0);
      sid = 1'b1;
      hold(20);
      chk("t2_data", 32'(serin_data), 32'h3C);
      chk("t2_ferr", 32'(frame_err), 32'h1);
      chk("t2_mferr", 32'(mfe), 32'h1);
      skres = 1'b1;
      cyc();
      chk("t2_ferr_clr", 32'(frame_err), 32'h0);
      chk("t2_valid", 32'(data_valid), 32'h1);

      // 3: overrun, then read in the completion clk
      clear();
      send(8'h11, 1'b1, 1'b0);
      hold(4);
      send(8'h22, 1'b1, 1'b0);
      hold(20);
      chk("t3_data", 32'(serin_data), 32'h22);
      chk("t3_ovr", 32'(overrun), 32'h1);
      clear();
      send(8'h11, 1'b1, 1'b0);
      hold(4);
      send(8'h22, 1'b1, 1'b1);
      hold(20);
      chk("t3b_ovr", 32'(overrun), 32'h0);
      chk("t3b_movr", 32'(mov), 32'h0);
      chk("t3b_valid", 32'(data_valid), 32'h1);

      // 4: 5-tick low glitch
      irq_cnt = 0;
      busy_cnt = 0;
      sid = 1'b0;
      hold(5);
      sid = 1'b1;
      hold(30);
      chk("t4_irqs", 32'(irq_cnt), 32'h0);
      chk("t4_busy", 32'(busy_cnt), 32'h8);
      chk("t4_idle", 32'(rx_busy), 32'h0);

      // 5: reset during data bit 4 of 0xFF, then 0x81
      sid = 1'b0;
      hold(OVS);
      sid = 1'b1;
      hold(OVS * 4 + OVS / 2);
      chk("t5_busy_pre", 32'(rx_busy), 32'h1);
      reset = 1'b1;
      cyc();
      cyc();
      chk("t5_data", 32'(serin_data), 32'h0);
      chk("t5_valid", 32'(data_valid), 32'h0);
      chk("t5_flags", 32'({serin_irq, frame_err, overrun}), 32'h0);
      chk("t5_busy", 32'(rx_busy), 32'h0);
      reset = 1'b0;
      hold(20);
      send(8'h81, 1'b1, 1'b0);
      hold(20);
      chk("t5_rx", 32'(serin_data), 32'h81);
      chk("t5_ferr", 32'(frame_err), 32'h0);

      // 6: enp one cycle in four, then a long break
      clear();
      per = 4;
      hold(10);
      send(8'h5A, 1'b1, 1'b0);
      hold(20);
      chk("t6_data", 32'(serin_data), 32'h5A);
      chk("t6_mdata", 32'(mdata), 32'h5A);
      per = 1;
      clear();
      per = 4;
      hold(4);
      irq_cnt = 0;
      sid = 1'b0;
      hold(30 * OVS);
      chk("t6_irqs", 32'(irq_cnt), 32'h1);
      chk("t6_ferr", 32'(frame_err), 32'h1);
      chk("t6_brk", 32'(serin_data), 32'h0);
      chk("t6_busy", 32'(rx_busy), 32'h0);
      sid = 1'b1;
      hold(20);
      chk("t6_irqs2", 32'(irq_cnt), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
